// File: rtl/multi_dataflow_stream_sequencer_if.sv
// Streamer control bundle between the job sequencer and the streamers.
// master = sequencer side, slave = streamer side.
interface multi_dataflow_stream_sequencer_if #(
  parameter int unsigned N_SRC = 3
);
  logic [N_SRC-1:0] src_ready_i;
  logic [N_SRC-1:0] src_done_i;
  logic [N_SRC-1:0] src_start_o;
  logic             sink_ready_i;
  logic             sink_done_i;
  logic             sink_start_o;
  logic             out_valid_i;
  logic             out_ready_i;

  modport master (
    input  src_ready_i,
    input  src_done_i,
    output src_start_o,
    input  sink_ready_i,
    input  sink_done_i,
    output sink_start_o,
    input  out_valid_i,
    input  out_ready_i
  );

  modport slave (
    output src_ready_i,
    output src_done_i,
    input  src_start_o,
    output sink_ready_i,
    output sink_done_i,
    input  sink_start_o,
    output out_valid_i,
    output out_ready_i
  );
endinterface

// File: rtl/multi_dataflow_stream_sequencer.sv
// Job sequencer: starts streamers/engine, counts output beats, pulses done.
// Optional watchdog enabled by MULTI_DATAFLOW_SEQ_TIMEOUT_EN.
module multi_dataflow_stream_sequencer #(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned N_SRC          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cnt_limit_i,
  multi_dataflow_stream_sequencer_if.master strm,
  output logic                 engine_start_o,
  output logic                 engine_enable_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] limit_q, limit_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [N_SRC-1:0]     src_done_q, src_done_d;
  logic                 sink_done_q, sink_done_d;
  logic                 beat;
  logic                 flags_open;

`ifdef MULTI_DATAFLOW_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
  logic            wd_active;
  logic            wd_hit;
`endif

  assign beat = strm.out_valid_i && strm.out_ready_i;
  assign flags_open = (state_q == S_START) ||
                      (state_q == S_RUN) ||
                      (state_q == S_DRAIN);

  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    beat_d      = beat_q;
    src_done_d  = src_done_q;
    sink_done_d = sink_done_q;
`ifdef MULTI_DATAFLOW_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
    wd_d        = '0;
    wd_active   = (state_q == S_WAIT) ||
                  (state_q == S_RUN) ||
                  (state_q == S_DRAIN);
    wd_hit      = wd_active &&
                  (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // done pulses are remembered so DRAIN can close as soon as it is entered
    if (flags_open) begin
      src_done_d  = src_done_q | strm.src_done_i;
      sink_done_d = sink_done_q | strm.sink_done_i;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          limit_d     = cnt_limit_i;
          beat_d      = '0;
          src_done_d  = '0;
          sink_done_d = 1'b0;
`ifdef MULTI_DATAFLOW_SEQ_TIMEOUT_EN
          tmo_d       = 1'b0;
`endif
          if (cnt_limit_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if ((&strm.src_ready_i) && strm.sink_ready_i) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (beat) begin
          beat_d = beat_q + CNT_WIDTH'(1);
          if (beat_q == limit_q - CNT_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((&src_done_q) && sink_done_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef MULTI_DATAFLOW_SEQ_TIMEOUT_EN
    if (wd_hit) begin
      state_d = S_DONE;
      tmo_d   = 1'b1;
    end
    // any sign of progress restarts the watchdog
    if (wd_active && (state_d == state_q) && !beat &&
        !(|strm.src_done_i) && !strm.sink_done_i) begin
      wd_d = wd_q + WD_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      limit_q     <= '0;
      beat_q      <= '0;
      src_done_q  <= '0;
      sink_done_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= S_IDLE;
      limit_q     <= '0;
      beat_q      <= '0;
      src_done_q  <= '0;
      sink_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      beat_q      <= beat_d;
      src_done_q  <= src_done_d;
      sink_done_q <= sink_done_d;
    end
  end

`ifdef MULTI_DATAFLOW_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else if (clear_i) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign strm.src_start_o  = {N_SRC{state_q == S_START}};
  assign strm.sink_start_o = (state_q == S_START);
  assign engine_start_o    = (state_q == S_START);
  assign engine_enable_o   = (state_q == S_RUN) ||
                             (state_q == S_DRAIN);
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign beat_cnt_o        = beat_q;

endmodule

// File: tb/tb_multi_dataflow_stream_sequencer.sv
// Directed bench for multi_dataflow_stream_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_multi_dataflow_stream_sequencer;
  localparam int CW = 32;
  localparam int NS = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] lim = '0;
  logic          eng_start;
  logic          eng_en;
  logic          busy;
  logic          done;
  logic          tmo;
  logic [CW-1:0] bcnt;

  int n_cmp = 0;
  int n_bad = 0;

  multi_dataflow_stream_sequencer_if #(.N_SRC(NS)) bus ();

  multi_dataflow_stream_sequencer #(
    .CNT_WIDTH(CW),
    .N_SRC(NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .clear_i(clear),
    .start_i(start),
    .cnt_limit_i(lim),
    .strm(bus),
    .engine_start_o(eng_start),
    .engine_enable_o(eng_en),
    .busy_o(busy),
    .done_o(done),
    .beat_cnt_o(bcnt),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  // {src_start[2:0], sink_start, eng_start, eng_en, busy, done}
  wire [7:0] ctl = {bus.src_start_o, bus.sink_start_o,
                    eng_start, eng_en, busy, done};

  typedef struct {
    logic          st;
    logic [CW-1:0] lm;
    logic [2:0]    sdn;
    logic          kdn;
    logic          ov;
    logic          ordy;
    logic [7:0]    e_ctl;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [CW-1:0] act,
                     input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    start            = 1'b0;
    bus.src_ready_i  = '1;
    bus.sink_ready_i = 1'b1;
    bus.src_done_i   = '0;
    bus.sink_done_i  = 1'b0;
    bus.out_valid_i  = 1'b0;
    bus.out_ready_i  = 1'b0;
  endtask

  task automatic add(input logic st, input logic [CW-1:0] lm,
                     input logic [2:0] sdn, input logic kdn,
                     input logic ov, input logic ordy,
                     input logic [7:0] ec, input logic [CW-1:0] en);
    vec_t v;
    v.st = st; v.lm = lm; v.sdn = sdn; v.kdn = kdn;
    v.ov = ov; v.ordy = ordy; v.e_ctl = ec; v.e_cnt = en;
    vt.push_back(v);
  endtask

  int bad;
  int seen;
  int n;
  logic got;

  initial begin
    idle_in();
    // nominal job, limit 8, one stalled beat, restart attempt in RUN
    add(1, 8, 3'b000, 0, 0, 0, 8'h00, 0);
    add(0, 0, 3'b000, 0, 0, 0, 8'h02, 0);
    add(0, 0, 3'b000, 0, 0, 0, 8'hFA, 0);
    add(0, 0, 3'b000, 0, 1, 1, 8'h06, 0);
    add(0, 0, 3'b000, 0, 1, 1, 8'h06, 1);
    add(0, 0, 3'b111, 0, 1, 0, 8'h06, 2);
    add(0, 0, 3'b000, 1, 1, 1, 8'h06, 2);
    add(1, 3, 3'b000, 0, 1, 1, 8'h06, 3);
    add(0, 0, 3'b000, 0, 1, 1, 8'h06, 4);
    add(0, 0, 3'b000, 0, 1, 1, 8'h06, 5);
    add(0, 0, 3'b000, 0, 1, 1, 8'h06, 6);
    add(0, 0, 3'b000, 0, 1, 1, 8'h06, 7);
    add(0, 0, 3'b000, 0, 1, 1, 8'h06, 8);
    add(0, 0, 3'b000, 0, 0, 0, 8'h03, 8);
    add(0, 0, 3'b000, 0, 0, 0, 8'h00, 8);

    #2;
    chk("reset ctl", CW'(ctl), 0);
    chk("reset cnt", bcnt, 0);
    chk("reset timeout", CW'(tmo), 0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step();
      start           = vt[i].st;
      lim             = vt[i].lm;
      bus.src_done_i  = vt[i].sdn;
      bus.sink_done_i = vt[i].kdn;
      bus.out_valid_i = vt[i].ov;
      bus.out_ready_i = vt[i].ordy;
      chk($sformatf("nominal%0d ctl", i), CW'(ctl), CW'(vt[i].e_ctl));
      chk($sformatf("nominal%0d cnt", i), bcnt, vt[i].e_cnt);
    end

    // late ready: src_ready[1] low for 5 cycles
    step(); idle_in();
    start = 1'b1; lim = 1; bus.src_ready_i = 3'b101;
    seen = 0;
    for (int k = 1; k <= 5; k++) begin
      step(); start = 1'b0;
      if (ctl[7:3] != 5'b0) seen++;
    end
    chk("late_ready early start", seen, 0);
    step(); bus.src_ready_i = '1;
    chk("late_ready waiting", CW'(ctl), 8'h02);
    step();
    chk("late_ready starts", CW'(ctl), 8'hFA);
    step();
    bus.out_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    bus.src_done_i = '1; bus.sink_done_i = 1'b1;
    step(); idle_in();
    chk("late_ready drain", CW'(ctl), 8'h06);
    chk("late_ready cnt", bcnt, 1);
    step();
    chk("late_ready done", CW'(ctl), 8'h03);
    step();
    chk("late_ready idle", CW'(ctl), 8'h00);

    // late sink done, beats keep coming during DRAIN
    step(); idle_in();
    start = 1'b1; lim = 2;
    step(); start = 1'b0;
    step();
    step();
    bus.out_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    bus.src_done_i = '1;
    step(); bus.src_done_i = '0;
    chk("late_done cnt1", bcnt, 1);
    bad = 0;
    for (int k = 5; k <= 24; k++) begin
      step();
      if (k == 24) bus.sink_done_i = 1'b1;
      if (ctl != 8'h06) bad++;
    end
    chk("late_done drain hold", bad, 0);
    step(); bus.sink_done_i = 1'b0; bus.out_valid_i = 1'b0;
    chk("late_done flag cycle", CW'(ctl), 8'h06);
    step();
    chk("late_done done", CW'(ctl), 8'h03);
    chk("late_done cnt", bcnt, 2);
    step();
    chk("late_done idle", CW'(ctl), 8'h00);

    // zero limit
    step(); idle_in();
    start = 1'b1; lim = 0;
    step(); start = 1'b0;
    chk("zero done", CW'(ctl), 8'h03);
    chk("zero cnt", bcnt, 0);
    step();
    chk("zero idle", CW'(ctl), 8'h00);

    // asynchronous reset in RUN
    step(); idle_in();
    start = 1'b1; lim = 4;
    step(); start = 1'b0;
    step();
    step(); bus.out_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    step(); bus.out_valid_i = 1'b0;
    chk("abort pre cnt", bcnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort rst ctl", CW'(ctl), 0);
    chk("abort rst cnt", bcnt, 0);
    step(); step();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (done || busy) bad++;
    end
    chk("abort rst quiet", bad, 0);

    // synchronous clear in DRAIN
    step(); idle_in();
    start = 1'b1; lim = 1;
    step(); start = 1'b0;
    step();
    step(); bus.out_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    step(); bus.out_valid_i = 1'b0;
    chk("clear in drain", CW'(ctl), 8'h06);
    clear = 1'b1;
    step(); clear = 1'b0;
    chk("clear ctl", CW'(ctl), 8'h00);
    chk("clear cnt", bcnt, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done || busy) bad++;
    end
    chk("clear quiet", bad, 0);

    // stalled job: watchdog or indefinite wait
    step(); idle_in();
    start = 1'b1; lim = 4;
    step(); start = 1'b0;
    step();
    step();
    chk("stall run", CW'(ctl), 8'h06);
`ifdef MULTI_DATAFLOW_SEQ_TIMEOUT_EN
    n = 0; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      step();
      n = k;
      if (done) got = 1'b1;
    end
    chk("timeout latency", n, 16);
    chk("timeout flag", CW'(tmo), 1);
    step();
    chk("timeout sticky", CW'(tmo), 1);
    chk("timeout idle", CW'(ctl), 8'h00);
    start = 1'b1; lim = 0;
    step(); start = 1'b0;
    chk("timeout cleared", CW'(tmo), 0);
    step();
`else
    repeat (1000) step();
    chk("no timeout busy", CW'(ctl), 8'h06);
    chk("no timeout flag", CW'(tmo), 0);
    clear = 1'b1;
    step(); clear = 1'b0;
    chk("no timeout cleared", CW'(busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_dataflow_stream_sequencer.md
# multi_dataflow_stream_sequencer

Job-level sequencer for the multi_dataflow HWPE. It starts the three source streamers (text, key, rc), the chiped_text sink streamer and the engine, then counts chiped_text output beats against the programmed limit. Once all streamers report completion it raises a single completion pulse. It sits between the control FSM/slave trigger and the streamer/engine control fields, and replaces ad-hoc start/done sequencing.

## Interface
- CNT_WIDTH, 32, width of beat limit and beat counter
- N_SRC, 3, number of source streamers (bit 0 text, 1 key, 2 rc)
- TIMEOUT_CYCLES, 4096, watchdog limit (used only with macro)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous clear, same effect as reset at next edge
- start_i  in  1  job trigger pulse; ignored unless state is IDLE
- cnt_limit_i  in  CNT_WIDTH  output beats per job (already +1 adjusted)
- src_ready_i  in  N_SRC  source streamer idle, accepts start
- src_done_i  in  N_SRC  source streamer done pulse
- sink_ready_i  in  1  sink streamer idle
- sink_done_i  in  1  sink streamer done pulse
- out_valid_i, out_ready_i  in  1 each  chiped_text stream handshake (observed only)
- src_start_o  out  N_SRC  one-cycle start pulse per source
- sink_start_o  out  1  one-cycle sink start pulse
- engine_start_o  out  1  one-cycle engine start pulse
- engine_enable_o  out  1  high in RUN and DRAIN
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- beat_cnt_o  out  CNT_WIDTH  beats counted in current job
- timeout_o  out  1  sticky watchdog flag

## Operation
- States: IDLE, WAIT_READY, START, RUN, DRAIN, DONE. Outputs are Moore, decoded from registered state.
- IDLE: on start_i, latch cnt_limit_i into limit_q, clear beat_cnt, done flags and timeout_o. If cnt_limit_i==0 go to DONE; otherwise go to WAIT_READY.
- WAIT_READY: go to START when &src_ready_i && sink_ready_i.
- START: one cycle. src_start_o='1, sink_start_o=1, engine_start_o=1. Go to RUN.
- RUN: a beat is out_valid_i && out_ready_i; each beat increments beat_cnt. A beat while beat_cnt==limit_q-1 moves to DRAIN, and beat_cnt ends equal to limit_q.
- DRAIN: beats are ignored (not counted). Go to DONE when all src_done_q bits and sink_done_q are set.
- Done flags: src_done_q[i] and sink_done_q are sticky. They set on the corresponding done pulse in START, RUN or DRAIN, and clear only when leaving IDLE. A done pulse arriving in RUN is retained, so DRAIN can exit after one cycle.
- DONE: done_o=1 for one cycle, then go to IDLE. beat_cnt_o holds until the next accepted start.
- start_i outside IDLE has no effect. A limit_q change mid-job is impossible because limit_q is latched.
- beat_cnt wraps never: the RUN exit at limit_q bounds it. Width is CNT_WIDTH, unsigned compare.

## Timing
- Reset/clear values: state IDLE; all outputs 0; beat_cnt_o 0; timeout_o 0.
- rst_ni low mid-job aborts immediately (asynchronously) and emits no done_o. clear_i aborts at the next edge, also without done_o.
- Latency: start_i sampled at edge t puts WAIT_READY in cycle t+1. If ready is high in t+1, start pulses occur in cycle t+2. Each extra not-ready cycle adds one cycle.
- Final beat at edge n puts DRAIN in n+1. If all flags are already set, done_o is high in cycle n+2.
- Zero limit: done_o is high in cycle t+1 with no start pulses.
- A done pulse and the final beat in the same cycle are both honoured.

## Configuration
- MULTI_DATAFLOW_SEQ_TIMEOUT_EN defined: a watchdog counter runs in WAIT_READY, RUN and DRAIN.
  - It resets on any beat, any done pulse, or any state change.
  - When it reaches TIMEOUT_CYCLES-1, the next state is DONE, timeout_o sets, and done_o pulses normally.
  - timeout_o clears on the next accepted start.
- Not defined: no counter; timeout_o is tied 0, and the FSM waits indefinitely.

## Test plan
- Nominal: limit 8, all ready, 8 beats, dones arrive during RUN -> start pulses at t+2, DRAIN after 8th beat, done_o exactly one cycle later, beat_cnt_o=8.
- Late ready: src_ready_i[1]=0 for 5 cycles -> start pulses delayed 5 cycles, all bits pulse together.
- Late dones: sink_done_i arrives 20 cycles after the final beat -> busy_o held through DRAIN, done_o in the cycle after the flag sets; extra beats in DRAIN leave beat_cnt_o=limit.
- Zero limit and ignored restart: cnt_limit_i=0 -> done_o at t+1, no start pulses; start_i during RUN -> no effect.
- Abort: rst_ni low mid-RUN -> all outputs 0 immediately, no done_o; clear_i mid-DRAIN -> IDLE next edge.
- Macro on, TIMEOUT_CYCLES=16, no beats -> done_o and timeout_o 16 cycles after RUN entry; macro off -> still busy after 1000 cycles.
